// File: rtl/vga_sync_sink_pkg.sv
// Shared types for the VGA sink: stream frame control, raster timing description,
// and the counter width used by the timing generator.
package vga_sync_sink_pkg;

    localparam int unsigned CNT_W = 16;

    typedef logic [CNT_W-1:0] cnt_t;

    // Frame control carried alongside every pixel beat.
    typedef struct packed {
        logic sof;  // first pixel of a frame
        logic eol;  // last pixel of a line
    } vga_fc_t;

    // Raster geometry: display, front porch, sync and back porch per axis.
    typedef struct packed {
        cnt_t h_display;
        cnt_t h_fp;
        cnt_t h_sync;
        cnt_t h_bp;
        cnt_t v_display;
        cnt_t v_fp;
        cnt_t v_sync;
        cnt_t v_bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_TIMING_640X480 = '{
        h_display: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
        v_display: 16'd480, v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33
    };

    // Total clocks per line (or lines per frame) for one axis.
    function automatic cnt_t axis_total(input cnt_t disp, input cnt_t fp,
                                        input cnt_t sync, input cnt_t bp);
        return disp + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_sink_timing_gen.sv
// Free-running raster timing: horizontal/vertical counters, active-region flag
// and unregistered sync levels. Shared with test-pattern sources.
module vga_timing_gen
    import vga_sync_sink_pkg::*;
#(
    parameter vga_timing_t TIMING   = VGA_TIMING_640X480,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    output cnt_t hcnt,
    output cnt_t vcnt,
    output logic active,
    output logic hsync,
    output logic vsync,
    output logic frame_last
);

    localparam cnt_t H_LAST_C  = axis_total(TIMING.h_display, TIMING.h_fp,
                                            TIMING.h_sync, TIMING.h_bp) - 16'd1;
    localparam cnt_t V_LAST_C  = axis_total(TIMING.v_display, TIMING.v_fp,
                                            TIMING.v_sync, TIMING.v_bp) - 16'd1;
    localparam cnt_t HS_BEG_C  = TIMING.h_display + TIMING.h_fp;
    localparam cnt_t HS_END_C  = TIMING.h_display + TIMING.h_fp + TIMING.h_sync;
    localparam cnt_t VS_BEG_C  = TIMING.v_display + TIMING.v_fp;
    localparam cnt_t VS_END_C  = TIMING.v_display + TIMING.v_fp + TIMING.v_sync;

    cnt_t hcnt_r;
    cnt_t vcnt_r;

    // Raster counters: hcnt wraps each line, vcnt advances on that wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_r <= 16'd0;
            vcnt_r <= 16'd0;
        end else if (hcnt_r == H_LAST_C) begin
            hcnt_r <= 16'd0;
            if (vcnt_r == V_LAST_C) begin
                vcnt_r <= 16'd0;
            end else begin
                vcnt_r <= vcnt_r + 16'd1;
            end
        end else begin
            hcnt_r <= hcnt_r + 16'd1;
        end
    end

    // Decode active region, sync windows and the last raster position.
    always_comb begin
        active     = (hcnt_r < TIMING.h_display) && (vcnt_r < TIMING.v_display);
        frame_last = (hcnt_r == H_LAST_C) && (vcnt_r == V_LAST_C);
        if ((hcnt_r >= HS_BEG_C) && (hcnt_r < HS_END_C)) begin
            hsync = SYNC_POL;
        end else begin
            hsync = ~SYNC_POL;
        end
        if ((vcnt_r >= VS_BEG_C) && (vcnt_r < VS_END_C)) begin
            vsync = SYNC_POL;
        end else begin
            vsync = ~SYNC_POL;
        end
    end

    assign hcnt = hcnt_r;
    assign vcnt = vcnt_r;

endmodule

// File: rtl/vga_sync_sink.sv
// Terminal video-stream consumer: locks the incoming frame to a free-running
// raster on sof and drives registered VGA pins. Loss of lock (underflow or
// misaligned frame control) raises a one-cycle error and re-searches for sof.
module vga_sync_sink
    import vga_sync_sink_pkg::*;
#(
    parameter int unsigned RGB_SIZE  = 12,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                src_vld,
    output logic                src_rdy,
    input  vga_fc_t             src_fc,
    input  logic [RGB_SIZE-1:0] src_rgb,
    output logic                vga_hsync,
    output logic                vga_vsync,
    output logic [RGB_SIZE-1:0] vga_rgb,
    output logic                locked,
    output logic                err_pulse
);

    localparam vga_timing_t TIMING_C = '{
        h_display: cnt_t'(H_DISPLAY), h_fp: cnt_t'(H_FP),
        h_sync:    cnt_t'(H_SYNC),    h_bp: cnt_t'(H_BP),
        v_display: cnt_t'(V_DISPLAY), v_fp: cnt_t'(V_FP),
        v_sync:    cnt_t'(V_SYNC),    v_bp: cnt_t'(V_BP)
    };
    localparam cnt_t H_LAST_PIX_C = cnt_t'(H_DISPLAY - 1);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISPLAY = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nx_s;

    cnt_t hcnt_s;
    cnt_t vcnt_s;
    logic active_s;
    logic hsync_pre_s;
    logic vsync_pre_s;
    logic frame_last_s;

    logic misalign_s;
    logic take_s;
    logic err_s;

    logic                hsync_r;
    logic                vsync_r;
    logic [RGB_SIZE-1:0] rgb_r;
    logic                locked_r;
    logic                err_r;

    vga_timing_gen #(
        .TIMING   (TIMING_C),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .hcnt       (hcnt_s),
        .vcnt       (vcnt_s),
        .active     (active_s),
        .hsync      (hsync_pre_s),
        .vsync      (vsync_pre_s),
        .frame_last (frame_last_s)
    );

    // Frame-control check for the beat at the head of the stream.
    always_comb begin
        misalign_s = (src_fc.sof && !((hcnt_s == 16'd0) && (vcnt_s == 16'd0)))
                   || (src_fc.eol != (hcnt_s == H_LAST_PIX_C));
    end

    // Lock FSM next state, ready and pixel-take/error decisions.
    // A misaligned beat is refused so it stays at the head; if it carries sof
    // it becomes the start of the next frame.
    always_comb begin
        state_nx_s = state_r;
        src_rdy    = 1'b0;
        take_s     = 1'b0;
        err_s      = 1'b0;
        case (state_r)
            ST_SEARCH: begin
                src_rdy = src_vld && !src_fc.sof;
                if (src_vld && src_fc.sof) begin
                    state_nx_s = ST_WAIT;
                end else begin
                    state_nx_s = ST_SEARCH;
                end
            end
            ST_WAIT: begin
                if (frame_last_s) begin
                    state_nx_s = ST_DISPLAY;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_DISPLAY: begin
                if (active_s) begin
                    src_rdy = !misalign_s;
                    if (!src_vld || misalign_s) begin
                        err_s      = 1'b1;
                        state_nx_s = ST_SEARCH;
                    end else begin
                        take_s     = 1'b1;
                        state_nx_s = ST_DISPLAY;
                    end
                end else begin
                    state_nx_s = ST_DISPLAY;
                end
            end
            default: begin
                state_nx_s = ST_SEARCH;
            end
        endcase
    end

    // Lock FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_SEARCH;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Output pins: pixel and syncs from the same raster position, one clock late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_r  <= ~SYNC_POL;
            vsync_r  <= ~SYNC_POL;
            rgb_r    <= {RGB_SIZE{1'b0}};
            locked_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            hsync_r  <= hsync_pre_s;
            vsync_r  <= vsync_pre_s;
            rgb_r    <= take_s ? src_rgb : {RGB_SIZE{1'b0}};
            locked_r <= (state_nx_s == ST_DISPLAY);
            err_r    <= err_s;
        end
    end

    assign vga_hsync = hsync_r;
    assign vga_vsync = vsync_r;
    assign vga_rgb   = rgb_r;
    assign locked    = locked_r;
    assign err_pulse = err_r;

endmodule

// File: tb/tb_vga_sync_sink.sv
// Randomized scoreboard bench for vga_sync_sink with a small raster
// (14 clocks x 7 lines). A reference model predicts each cycle's pin values;
// a separate monitor compares them one clock later.
module tb_vga_sync_sink;
    import vga_sync_sink_pkg::*;

    localparam int HD = 8, HFP = 2, HS = 2, HB = 2;
    localparam int VD = 4, VFP = 1, VS = 1, VB = 1;
    localparam int HT = HD + HFP + HS + HB;   // 14
    localparam int VT = VD + VFP + VS + VB;   // 7
    localparam int FRAME = HT * VT;           // 98

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        src_vld = 1'b0;
    logic        src_rdy;
    vga_fc_t     src_fc = '0;
    logic [11:0] src_rgb = 12'd0;
    logic        vga_hsync;
    logic        vga_vsync;
    logic [11:0] vga_rgb;
    logic        locked;
    logic        err_pulse;

    vga_sync_sink #(
        .RGB_SIZE(12), .H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .src_vld(src_vld), .src_rdy(src_rdy),
        .src_fc(src_fc), .src_rgb(src_rgb), .vga_hsync(vga_hsync),
        .vga_vsync(vga_vsync), .vga_rgb(vga_rgb), .locked(locked),
        .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    typedef struct { logic [11:0] rgb; logic sof; logic eol; } beat_t;
    typedef struct { int due; logic hs; logic vs; logic [11:0] rgb; logic lk; logic er; } exp_t;

    beat_t strm[$];
    exp_t  sb[$];
    int    checks = 0;
    int    failures = 0;
    int    n;               // clocks since reset release == raster position index
    bit    model_en = 1'b0;
    int    mode = 0;        // 0: hunting for sof, 1: sof held, 2: showing frame
    int    gap_pos = -1;    // raster position at which one valid bubble is inserted

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t n=%0d", nm, act, exp, $time, n);
        end
    endtask

    // Frame beats with stream index idx in [first, first+count): sof on index 0, eol each line end.
    task automatic push_frame(input int first, input int count);
        beat_t b;
        for (int i = first; i < first + count; i++) begin
            b.rgb = 12'($urandom_range(4095, 1));
            b.sof = (i == 0);
            b.eol = ((i % HD) == HD - 1);
            strm.push_back(b);
        end
    endtask

    task automatic push_junk(input int count);
        beat_t b;
        for (int i = 0; i < count; i++) begin
            b.rgb = 12'($urandom_range(4095, 1));
            b.sof = 1'b0;
            b.eol = 1'($urandom_range(1, 0));
            strm.push_back(b);
        end
    endtask

    task automatic check_reset_pins(input string tag);
        chk({tag, "_hsync"}, 32'(vga_hsync), 32'd1);
        chk({tag, "_vsync"}, 32'(vga_vsync), 32'd1);
        chk({tag, "_rgb"}, 32'(vga_rgb), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_err"}, 32'(err_pulse), 32'd0);
        chk({tag, "_src_rdy"}, 32'(src_rdy), 32'd0);
    endtask

    task automatic wait_locked(input string nm);
        int k;
        k = 0;
        while (locked !== 1'b1 && k < 3 * FRAME) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(locked), 32'd1);
    endtask

    // Position counter mirroring elapsed clocks since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    // Stream driver: retire the head on handshake, then present the next beat.
    initial begin
        bit hs_seen;
        bit gap;
        forever begin
            @(posedge clk);
            hs_seen = rst_n && src_vld && src_rdy;
            #1;
            if (hs_seen && strm.size() > 0) void'(strm.pop_front());
            gap = (gap_pos >= 0) && ((n % FRAME) == gap_pos);
            if (gap) gap_pos = -1;
            if (strm.size() > 0 && !gap) begin
                src_vld    = 1'b1;
                src_rgb    = strm[0].rgb;
                src_fc.sof = strm[0].sof;
                src_fc.eol = strm[0].eol;
            end else begin
                src_vld = 1'b0;
                src_rgb = 12'd0;
                src_fc  = '0;
            end
        end
    end

    // Reference model: from raster position and the presented beat, predict
    // ready now and the pins one clock later.
    always @(negedge clk) begin
        int p, h, v, nx;
        bit act, rdy, mis, er;
        exp_t e;
        if (model_en && rst_n) begin
            p   = n % FRAME;
            h   = p % HT;
            v   = p / HT;
            act = (h < HD) && (v < VD);
            rdy = 1'b0;
            er  = 1'b0;
            nx  = mode;
            e.rgb = 12'd0;
            if (mode == 0) begin
                rdy = src_vld && !src_fc.sof;
                if (src_vld && src_fc.sof) nx = 1;
            end else if (mode == 1) begin
                if (p == FRAME - 1) nx = 2;
            end else if (act) begin
                mis = (src_fc.sof && p != 0) || (src_fc.eol != (h == HD - 1));
                rdy = !mis;
                if (!src_vld || mis) begin
                    er = 1'b1;
                    nx = 0;
                end else begin
                    e.rgb = src_rgb;
                end
            end
            chk("src_rdy", 32'(src_rdy), 32'(rdy));
            mode  = nx;
            e.due = n + 1;
            e.hs  = !((h >= HD + HFP) && (h < HD + HFP + HS));
            e.vs  = !((v >= VD + VFP) && (v < VD + VFP + VS));
            e.lk  = (nx == 2);
            e.er  = er;
            sb.push_back(e);
        end
    end

    // Monitor: compare pins against predictions that have come due.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= n) begin
            e = sb.pop_front();
            chk("vga_hsync", 32'(vga_hsync), 32'(e.hs));
            chk("vga_vsync", 32'(vga_vsync), 32'(e.vs));
            chk("vga_rgb", 32'(vga_rgb), 32'(e.rgb));
            chk("locked", 32'(locked), 32'(e.lk));
            chk("err_pulse", 32'(err_pulse), 32'(e.er));
        end
    end

    initial begin
        int k;
        repeat (2) @(posedge clk);
        #1;
        check_reset_pins("reset");
        rst_n = 1'b1;
        model_en = 1'b1;

        // Idle raster: syncs only, no lock.
        repeat (2 * FRAME) @(posedge clk);

        // Junk beats ahead of frames arriving mid-raster.
        push_junk(5);
        push_frame(0, HD * VD);
        push_frame(0, HD * VD);
        push_frame(0, HD * VD);
        repeat (5 * FRAME) @(posedge clk);

        // One-cycle underflow at (3,1) while locked.
        push_frame(0, HD * VD);
        push_frame(0, HD * VD);
        push_frame(0, HD * VD);
        wait_locked("lock_before_gap");
        gap_pos = 1 * HT + 3;
        repeat (4 * FRAME) @(posedge clk);

        // Early sof at (5,2): partial frame then complete frames.
        push_frame(0, 2 * HD + 5);
        push_frame(0, HD * VD);
        push_frame(0, HD * VD);
        wait_locked("lock_before_sof");
        repeat (4 * FRAME) @(posedge clk);

        // Reset at (4,2) while locked, held for 3 clocks.
        push_frame(0, HD * VD);
        push_frame(0, HD * VD);
        wait_locked("lock_before_rst");
        k = 0;
        while ((n % FRAME) != 2 * HT + 4 && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        chk("reach_4_2", 32'(n % FRAME), 32'(2 * HT + 4));
        model_en = 1'b0;
        #1;
        rst_n = 1'b0;
        sb.delete();
        strm.delete();
        src_vld = 1'b0;
        src_fc  = '0;
        src_rgb = 12'd0;
        #1;
        check_reset_pins("midrst");
        repeat (3) @(posedge clk);
        #1;
        mode = 0;
        rst_n = 1'b1;
        model_en = 1'b1;
        repeat (FRAME / 2) @(posedge clk);
        push_frame(0, HD * VD);
        push_frame(0, HD * VD);
        repeat (4 * FRAME) @(posedge clk);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
